// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable divider, h/v raster counters, syncs, strobes and frame counter.
// Decode is taken from next-state counters, so sync/active flops line up with the counter values shown.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int FRAME_W  = 16,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW      = $clog2(H_TOTAL),
   localparam int VW      = $clog2(V_TOTAL)
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               enable,
   output logic               pix_en,
   output logic [HW-1:0]      hcount,
   output logic [VW-1:0]      vcount,
   output logic               active,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_count,
   output logic               VGA_CLK,
   output logic               VGA_HS,
   output logic               VGA_VS,
   output logic               VGA_BLANK_N,
   output logic               VGA_SYNC_N
);

   localparam int DW          = $clog2(CLK_DIV);
   localparam int H_SYNC_BEG  = H_ACTIVE + H_FP;
   localparam int H_SYNC_END  = H_ACTIVE + H_FP + H_SYNC;
   localparam int V_SYNC_BEG  = V_ACTIVE + V_FP;
   localparam int V_SYNC_END  = V_ACTIVE + V_FP + V_SYNC;

   if (CLK_DIV < 2 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : gBadParam
      $error("vga_timing_gen: CLK_DIV must be >= 2 and every H_*/V_* parameter nonzero");
   end

   logic [DW-1:0] divCnt;
   logic [DW-1:0] divNext;
   logic [HW-1:0] hNext;
   logic [VW-1:0] vNext;
   logic          divLast;
   logic          tick;
   logic          hWrap;
   logic          vWrap;
   logic          lineWrap;
   logic          frameWrap;

   assign divLast     = (divCnt == DW'(CLK_DIV - 1));
   assign tick        = enable && divLast;
   assign pix_en      = tick && !reset;
   assign hWrap       = (hcount == HW'(H_TOTAL - 1));
   assign vWrap       = (vcount == VW'(V_TOTAL - 1));
   assign lineWrap    = tick && hWrap;
   assign frameWrap   = lineWrap && vWrap;
   assign VGA_BLANK_N = active;
   assign VGA_SYNC_N  = 1'b0;

   // With enable low every next value equals the current one, so all decoded outputs hold too.
   always_comb begin
      divNext = divCnt;
      hNext   = hcount;
      vNext   = vcount;
      if (enable) begin
         divNext = divLast ? '0 : divCnt + DW'(1);
      end
      if (tick) begin
         hNext = hWrap ? '0 : hcount + HW'(1);
      end
      if (lineWrap) begin
         vNext = vWrap ? '0 : vcount + VW'(1);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         divCnt      <= '0;
         hcount      <= '0;
         vcount      <= '0;
         frame_count <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         VGA_CLK     <= 1'b0;
         VGA_HS      <= ~HS_POL;
         VGA_VS      <= ~VS_POL;
         active      <= 1'b1;
      end else begin
         divCnt      <= divNext;
         hcount      <= hNext;
         vcount      <= vNext;
         line_start  <= lineWrap;
         frame_start <= frameWrap;
         if (frameWrap) begin
            frame_count <= frame_count + FRAME_W'(1);
         end
         VGA_CLK <= (divNext >= DW'(CLK_DIV / 2));
         VGA_HS  <= (hNext >= HW'(H_SYNC_BEG) && hNext < HW'(H_SYNC_END)) ? HS_POL : ~HS_POL;
         VGA_VS  <= (vNext >= VW'(V_SYNC_BEG) && vNext < VW'(V_SYNC_END)) ? VS_POL : ~VS_POL;
         active  <= (hNext < HW'(H_ACTIVE)) && (vNext < VW'(V_ACTIVE));
      end
   end

endmodule
